// File: rtl/mvu_job_dispatcher.sv
// mvu_job_dispatcher: per-hart MVU job queue, round-robin issue, completion irq back to the CSR file.
// Optional RUN watchdog enabled by defining MVU_DISPATCH_TIMEOUT_EN.
package pito_pkg;
    localparam int HART_CNT_WIDTH = 3;
endpackage

module mvu_job_dispatcher #(
    parameter int NUM_HARTS      = 8,
    parameter int HART_W         = pito_pkg::HART_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_HARTS-1:0]      mvu_start,
    input  logic [29*NUM_HARTS-1:0]   csr_mvu_countdown,
    output logic                      job_valid_o,
    input  logic                      job_ready_i,
    output logic [HART_W-1:0]         job_hart_o,
    output logic [28:0]               job_countdown_o,
    input  logic                      mvu_done_i,
    input  logic [HART_W-1:0]         mvu_done_hart_i,
    output logic [NUM_HARTS-1:0]      mvu_irq,
    output logic [NUM_HARTS-1:0]      hart_busy_o,
    output logic [NUM_HARTS-1:0]      start_drop_o,
    output logic                      mvu_busy_o,
    output logic                      timeout_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;
    state_t state, state_nxt;
    logic [NUM_HARTS-1:0] pending, pending_nxt, active, busy, busy_nxt, start_ok, irq_nxt, cur_oh;
    logic [28:0] snap [NUM_HARTS];
    logic [28:0] cd_nxt;
    logic [HART_W-1:0] cur_hart, cur_nxt, last_grant, last_nxt, pick;
    logic valid_nxt, done_match, handshake, expire, finish, found;

    assign cur_oh     = NUM_HARTS'(1) << cur_hart;
    assign done_match = state == RUN && mvu_done_i && mvu_done_hart_i == cur_hart;
    assign handshake  = state == ISSUE && job_ready_i;
    assign finish     = done_match | expire;
    // a finishing job frees its hart so a same-cycle start is accepted
    assign active     = (state != IDLE && !finish) ? cur_oh : '0;
    assign busy       = pending | active;
    assign start_ok   = mvu_start & ~busy;
    assign job_hart_o = cur_hart;

    always_comb begin
        state_nxt   = state;
        cur_nxt     = cur_hart;
        last_nxt    = last_grant;
        valid_nxt   = job_valid_o;
        cd_nxt      = job_countdown_o;
        irq_nxt     = '0;
        pending_nxt = pending | start_ok;
        found       = 1'b0;
        pick        = last_grant;
        for (int i = 1; i <= NUM_HARTS; i++) begin
            if (!found && pending[(int'(last_grant) + i) % NUM_HARTS]) begin
                found = 1'b1;
                pick  = HART_W'((int'(last_grant) + i) % NUM_HARTS);
            end
        end
        if (state == IDLE && found) begin
            state_nxt = ISSUE;
            cur_nxt   = pick;
            last_nxt  = pick;
            valid_nxt = 1'b1;
            cd_nxt    = snap[pick];
        end
        if (handshake) begin
            state_nxt             = RUN;
            valid_nxt             = 1'b0;
            pending_nxt[cur_hart] = 1'b0;
        end
        if (finish) begin
            state_nxt = IDLE;
            irq_nxt   = cur_oh;
        end
        busy_nxt = pending_nxt | ((state_nxt != IDLE) ? (NUM_HARTS'(1) << cur_nxt) : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pending         <= '0;
            cur_hart        <= '0;
            last_grant      <= HART_W'(NUM_HARTS - 1);
            job_valid_o     <= 1'b0;
            job_countdown_o <= '0;
            mvu_irq         <= '0;
            hart_busy_o     <= '0;
            start_drop_o    <= '0;
            mvu_busy_o      <= 1'b0;
            for (int h = 0; h < NUM_HARTS; h++) snap[h] <= '0;
        end else begin
            state           <= state_nxt;
            pending         <= pending_nxt;
            cur_hart        <= cur_nxt;
            last_grant      <= last_nxt;
            job_valid_o     <= valid_nxt;
            job_countdown_o <= cd_nxt;
            mvu_irq         <= irq_nxt;
            hart_busy_o     <= busy_nxt;
            start_drop_o    <= mvu_start & busy;
            mvu_busy_o      <= state_nxt != IDLE;
            for (int h = 0; h < NUM_HARTS; h++)
                if (start_ok[h]) snap[h] <= csr_mvu_countdown[h*29 +: 29];
        end
    end

`ifdef MVU_DISPATCH_TIMEOUT_EN
    logic [31:0] run_cnt;
    assign expire = state == RUN && !done_match && run_cnt == 32'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt   <= '0;
            timeout_o <= 1'b0;
        end else begin
            run_cnt   <= (state == RUN) ? run_cnt + 32'd1 : '0;
            timeout_o <= timeout_o | expire;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign expire         = 1'b0;
    assign timeout_o      = 1'b0;
`endif
endmodule

// File: tb/tb_mvu_job_dispatcher.sv
// tb_mvu_job_dispatcher: table-driven directed checks plus hand sequences for backpressure, reset and watchdog.
module tb_mvu_job_dispatcher;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  mvu_start = '0;
    logic [231:0] csr = '0;
    logic        job_valid, job_ready = 1'b0;
    logic [2:0]  job_hart;
    logic [28:0] job_cd;
    logic        mvu_done = 1'b0;
    logic [2:0]  done_hart = '0;
    logic [7:0]  mvu_irq, hart_busy, start_drop;
    logic        mvu_busy, timeout;
    int          checks = 0;
    int          errors = 0;

    mvu_job_dispatcher #(.NUM_HARTS(8), .HART_W(3), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .mvu_start(mvu_start), .csr_mvu_countdown(csr),
        .job_valid_o(job_valid), .job_ready_i(job_ready), .job_hart_o(job_hart),
        .job_countdown_o(job_cd), .mvu_done_i(mvu_done), .mvu_done_hart_i(done_hart),
        .mvu_irq(mvu_irq), .hart_busy_o(hart_busy), .start_drop_o(start_drop),
        .mvu_busy_o(mvu_busy), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rs;
        logic [7:0]  start;
        logic        ready;
        logic        done;
        logic [2:0]  dh;
        logic        ev;
        logic [2:0]  eh;
        logic [28:0] ecd;
        logic [7:0]  eirq;
        logic [7:0]  ebusy;
        logic [7:0]  edrop;
        logic        emb;
    } vec_t;
    vec_t tv [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rs, input logic [7:0] st, input logic rd, input logic dn, input logic [2:0] dh,
                       input logic ev, input logic [2:0] eh, input logic [28:0] ecd, input logic [7:0] eirq,
                       input logic [7:0] ebusy, input logic [7:0] edrop, input logic emb);
        vec_t v;
        v = '{rs, st, rd, dn, dh, ev, eh, ecd, eirq, ebusy, edrop, emb};
        tv.push_back(v);
    endtask

    initial begin
        int n;
        for (int h = 0; h < 8; h++) csr[h*29 +: 29] = 29'h0A0 + 29'(h) * 29'h20;
        // single job on hart 3
        add(0, 8'h08, 1, 0, 0, 0, 0, 29'h000, 8'h00, 8'h08, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 1, 3, 29'h100, 8'h00, 8'h08, 8'h00, 1);
        add(0, 8'h00, 1, 0, 0, 0, 3, 29'h100, 8'h00, 8'h08, 8'h00, 1);
        add(0, 8'h00, 1, 1, 3, 0, 3, 29'h100, 8'h08, 8'h00, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 0, 3, 29'h100, 8'h00, 8'h00, 8'h00, 0);
        // round robin 0,2,5 from reset, then 0 before 5 with last_grant 5
        add(1, 8'h25, 1, 0, 0, 0, 0, 29'h000, 8'h00, 8'h25, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 1, 0, 29'h0A0, 8'h00, 8'h25, 8'h00, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0, 29'h0A0, 8'h00, 8'h25, 8'h00, 1);
        add(0, 8'h00, 1, 1, 0, 0, 0, 29'h0A0, 8'h01, 8'h24, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 1, 2, 29'h0E0, 8'h00, 8'h24, 8'h00, 1);
        add(0, 8'h00, 1, 0, 0, 0, 2, 29'h0E0, 8'h00, 8'h24, 8'h00, 1);
        add(0, 8'h00, 1, 1, 2, 0, 2, 29'h0E0, 8'h04, 8'h20, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 1, 5, 29'h140, 8'h00, 8'h20, 8'h00, 1);
        add(0, 8'h00, 1, 0, 0, 0, 5, 29'h140, 8'h00, 8'h20, 8'h00, 1);
        add(0, 8'h00, 1, 1, 5, 0, 5, 29'h140, 8'h20, 8'h00, 8'h00, 0);
        add(0, 8'h21, 1, 0, 0, 0, 5, 29'h140, 8'h00, 8'h21, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 1, 0, 29'h0A0, 8'h00, 8'h21, 8'h00, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0, 29'h0A0, 8'h00, 8'h21, 8'h00, 1);
        add(0, 8'h00, 1, 1, 0, 0, 0, 29'h0A0, 8'h01, 8'h20, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 1, 5, 29'h140, 8'h00, 8'h20, 8'h00, 1);
        add(0, 8'h00, 1, 0, 0, 0, 5, 29'h140, 8'h00, 8'h20, 8'h00, 1);
        add(0, 8'h00, 1, 1, 5, 0, 5, 29'h140, 8'h20, 8'h00, 8'h00, 0);
        // drop while running, then start accepted in the same cycle as its done
        add(0, 8'h02, 1, 0, 0, 0, 5, 29'h140, 8'h00, 8'h02, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 1, 1, 29'h0C0, 8'h00, 8'h02, 8'h00, 1);
        add(0, 8'h00, 1, 0, 0, 0, 1, 29'h0C0, 8'h00, 8'h02, 8'h00, 1);
        add(0, 8'h02, 1, 0, 0, 0, 1, 29'h0C0, 8'h00, 8'h02, 8'h02, 1);
        add(0, 8'h00, 1, 0, 0, 0, 1, 29'h0C0, 8'h00, 8'h02, 8'h00, 1);
        add(0, 8'h02, 1, 1, 1, 0, 1, 29'h0C0, 8'h02, 8'h02, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 1, 1, 29'h0C0, 8'h00, 8'h02, 8'h00, 1);
        add(0, 8'h00, 1, 0, 0, 0, 1, 29'h0C0, 8'h00, 8'h02, 8'h00, 1);
        add(0, 8'h00, 1, 1, 1, 0, 1, 29'h0C0, 8'h02, 8'h00, 8'h00, 0);
        // done ignored in ISSUE, mismatched in RUN, and in IDLE
        add(0, 8'h10, 1, 0, 0, 0, 1, 29'h0C0, 8'h00, 8'h10, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 1, 4, 29'h120, 8'h00, 8'h10, 8'h00, 1);
        add(0, 8'h00, 0, 1, 4, 1, 4, 29'h120, 8'h00, 8'h10, 8'h00, 1);
        add(0, 8'h00, 1, 0, 0, 0, 4, 29'h120, 8'h00, 8'h10, 8'h00, 1);
        add(0, 8'h00, 1, 1, 6, 0, 4, 29'h120, 8'h00, 8'h10, 8'h00, 1);
        add(0, 8'h00, 1, 1, 4, 0, 4, 29'h120, 8'h10, 8'h00, 8'h00, 0);
        add(0, 8'h00, 1, 1, 4, 0, 4, 29'h120, 8'h00, 8'h00, 8'h00, 0);

        #12 rst_n = 1'b1;
        chk("reset_valid", 32'(job_valid), 0);
        chk("reset_busy", 32'(hart_busy), 0);
        chk("reset_timeout", 32'(timeout), 0);
        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rs) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            mvu_start = tv[i].start;
            job_ready = tv[i].ready;
            mvu_done  = tv[i].done;
            done_hart = tv[i].dh;
            tick();
            chk($sformatf("row%0d_valid", i), 32'(job_valid), 32'(tv[i].ev));
            chk($sformatf("row%0d_hart", i), 32'(job_hart), 32'(tv[i].eh));
            chk($sformatf("row%0d_cd", i), 32'(job_cd), 32'(tv[i].ecd));
            chk($sformatf("row%0d_irq", i), 32'(mvu_irq), 32'(tv[i].eirq));
            chk($sformatf("row%0d_busy", i), 32'(hart_busy), 32'(tv[i].ebusy));
            chk($sformatf("row%0d_drop", i), 32'(start_drop), 32'(tv[i].edrop));
            chk($sformatf("row%0d_mbusy", i), 32'(mvu_busy), 32'(tv[i].emb));
        end
        mvu_start = '0; mvu_done = 1'b0;

        // backpressure on hart 6; CSR changes after capture must not leak through
        mvu_start = 8'h40; job_ready = 1'b0;
        tick();
        mvu_start = '0;
        tick();
        csr[6*29 +: 29] = 29'h1FFFFFFF;
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", 32'(job_valid), 1);
            chk("bp_hart", 32'(job_hart), 6);
            chk("bp_cd", 32'(job_cd), 32'h160);
            if (c < 9) tick();
        end
        job_ready = 1'b1;
        tick();
        chk("bp_accept_valid", 32'(job_valid), 0);
        chk("bp_accept_mbusy", 32'(mvu_busy), 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_no_dup", 32'(job_valid), 0);
        end
        mvu_done = 1'b1; done_hart = 3'd6;
        tick();
        mvu_done = 1'b0;
        chk("bp_irq", 32'(mvu_irq), 32'h40);
        chk("bp_busy", 32'(hart_busy), 0);
        csr[6*29 +: 29] = 29'h160;

        // reset mid-RUN with hart 2 still pending
        mvu_start = 8'h05;
        tick();
        mvu_start = '0;
        tick();
        chk("rr_pick0", 32'(job_hart), 0);
        tick();
        chk("mid_run_busy", 32'(hart_busy), 32'h05);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(job_valid), 0);
        chk("arst_busy", 32'(hart_busy), 0);
        chk("arst_mbusy", 32'(mvu_busy), 0);
        chk("arst_cd", 32'(job_cd), 0);
        chk("arst_irq", 32'(mvu_irq), 0);
        mvu_done = 1'b1; done_hart = 3'd0;
        tick();
        mvu_done = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_irq", 32'(mvu_irq), 0);
            chk("post_rst_valid", 32'(job_valid), 0);
            chk("post_rst_busy", 32'(hart_busy), 0);
        end

`ifdef MVU_DISPATCH_TIMEOUT_EN
        mvu_start = 8'h08;
        tick();
        mvu_start = '0;
        tick();
        tick();
        n = 0;
        while (mvu_irq == 8'h00 && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycles", 32'(n), 16);
        chk("to_irq", 32'(mvu_irq), 32'h08);
        chk("to_flag", 32'(timeout), 1);
        chk("to_mbusy", 32'(mvu_busy), 0);
        tick();
        chk("to_sticky", 32'(timeout), 1);
`else
        n = 0;
        mvu_start = 8'h08;
        tick();
        mvu_start = '0;
        tick();
        tick();
        repeat (20) begin
            tick();
            if (mvu_irq != 8'h00) n++;
        end
        chk("no_to_irq", 32'(n), 0);
        chk("no_to_mbusy", 32'(mvu_busy), 1);
        chk("no_to_flag", 32'(timeout), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
